// File: rtl/reg_pair_sequencer_if.sv
// Command / register-file bundle for reg_pair_sequencer.
// slave: the sequencer. master: the command issuer plus register-file read data.
interface reg_pair_sequencer_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 3
);
  logic                       i_start;
  logic [1:0]                 i_op;
  logic [1:0]                 i_pair;
  logic [2*DATA_WIDTH-1:0]    i_imm;
  logic [DATA_WIDTH-1:0]      i_rf_data;
  logic [ADDRESS_WIDTH-1:0]   o_rf_addr;
  logic                       o_rf_rd_en;
  logic                       o_rf_wr_en;
  logic [DATA_WIDTH-1:0]      o_rf_data;
  logic                       o_busy;
  logic                       o_done;
  logic                       o_error;
  logic                       o_carry;
  logic [2*DATA_WIDTH-1:0]    o_result;

  modport slave (
    input  i_start, i_op, i_pair, i_imm, i_rf_data,
    output o_rf_addr, o_rf_rd_en, o_rf_wr_en, o_rf_data,
           o_busy, o_done, o_error, o_carry, o_result
  );

  modport master (
    output i_start, i_op, i_pair, i_imm, i_rf_data,
    input  o_rf_addr, o_rf_rd_en, o_rf_wr_en, o_rf_data,
           o_busy, o_done, o_error, o_carry, o_result
  );
endinterface

// File: rtl/reg_pair_sequencer.sv
// Register-pair sequencer: LOAD / INC / DEC (and optional READ) on the
// BC, DE and HL pairs of an 8-entry register file, one byte per access.
// Optional feature: define GB80_REG_PAIR_READ_EN to enable op 11 (READ);
// without it op 11 is reported as an error.
module reg_pair_sequencer #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 3
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  reg_pair_sequencer_if.slave  bus
);

  localparam int PW = 2 * DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE, RD_LO, RD_HI, CAP_HI, WR_LO, WR_HI, DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_LOAD, OP_INC, OP_DEC, OP_READ
  } op_e;

  state_e                   state, state_n;
  op_e                      op_q;
  logic [1:0]               pair_q;
  logic [PW-1:0]            work_q, work_d;
  logic                     carry_q, carry_d;
  logic                     err_q, err_d;
  logic [PW-1:0]            result_q;
  logic                     carry_out_q;
  logic                     error_out_q;
  logic                     start_invalid;
  logic [ADDRESS_WIDTH-1:0] lo_addr, hi_addr;
  logic [PW-1:0]            pair_val;

  // Low register sits at the odd address, high register at the even one.
  assign lo_addr  = ADDRESS_WIDTH'({pair_q, 1'b1});
  assign hi_addr  = ADDRESS_WIDTH'({pair_q, 1'b0});
  assign pair_val = {bus.i_rf_data, work_q[DATA_WIDTH-1:0]};

`ifdef GB80_REG_PAIR_READ_EN
  assign start_invalid = (bus.i_pair == 2'b11);
`else
  assign start_invalid = (bus.i_pair == 2'b11) || (bus.i_op == 2'b11);
`endif

  // Next state, register-file strobes and working-value updates.
  always_comb begin
    state_n        = state;
    work_d         = work_q;
    carry_d        = carry_q;
    err_d          = err_q;
    bus.o_rf_rd_en = 1'b0;
    bus.o_rf_wr_en = 1'b0;
    bus.o_rf_addr  = '0;
    bus.o_rf_data  = '0;
    case (state)
      IDLE: begin
        if (bus.i_start) begin
          work_d  = bus.i_imm;
          carry_d = 1'b0;
          err_d   = start_invalid;
          if (start_invalid)          state_n = DONE;
          else if (bus.i_op == 2'b00) state_n = WR_LO;
          else                        state_n = RD_LO;
        end
      end
      RD_LO: begin
        bus.o_rf_rd_en = 1'b1;
        bus.o_rf_addr  = lo_addr;
        state_n        = RD_HI;
      end
      RD_HI: begin
        bus.o_rf_rd_en             = 1'b1;
        bus.o_rf_addr              = hi_addr;
        work_d[DATA_WIDTH-1:0]     = bus.i_rf_data;
        state_n                    = CAP_HI;
      end
      CAP_HI: begin
        state_n = WR_LO;
        case (op_q)
          OP_INC: begin
            work_d  = pair_val + PW'(1);
            carry_d = &pair_val;
          end
          OP_DEC: begin
            work_d  = pair_val - PW'(1);
            carry_d = ~|pair_val;
          end
`ifdef GB80_REG_PAIR_READ_EN
          OP_READ: begin
            work_d  = pair_val;
            carry_d = 1'b0;
            state_n = DONE;
          end
`endif
          default: begin
            work_d  = pair_val;
            carry_d = 1'b0;
          end
        endcase
      end
      WR_LO: begin
        bus.o_rf_wr_en = 1'b1;
        bus.o_rf_addr  = lo_addr;
        bus.o_rf_data  = work_q[DATA_WIDTH-1:0];
        state_n        = WR_HI;
      end
      WR_HI: begin
        bus.o_rf_wr_en = 1'b1;
        bus.o_rf_addr  = hi_addr;
        bus.o_rf_data  = work_q[PW-1:DATA_WIDTH];
        state_n        = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, latched command, working value and held results.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      op_q        <= OP_LOAD;
      pair_q      <= '0;
      work_q      <= '0;
      carry_q     <= 1'b0;
      err_q       <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      error_out_q <= 1'b0;
    end else begin
      state   <= state_n;
      work_q  <= work_d;
      carry_q <= carry_d;
      err_q   <= err_d;
      if (state == IDLE && bus.i_start) begin
        op_q   <= op_e'(bus.i_op);
        pair_q <= bus.i_pair;
      end
      // Outputs load from the next-cycle values so they are already valid
      // in the DONE cycle, including the direct IDLE->DONE error path.
      if (state_n == DONE) begin
        result_q    <= err_d ? '0 : work_d;
        carry_out_q <= carry_d;
        error_out_q <= err_d;
      end
    end
  end

  assign bus.o_busy   = (state != IDLE);
  assign bus.o_done   = (state == DONE);
  assign bus.o_result = result_q;
  assign bus.o_carry  = carry_out_q;
  assign bus.o_error  = error_out_q;

endmodule
